// File: rtl/mvu_pkg.sv
// Shared helpers for MVU/VVU output paths: signed narrowing with
// saturation or wrap, reported together with an overflow flag.
package mvu_pkg;

  localparam int MAX_W = 64;

  typedef struct packed {
    logic             ovf;
    logic [MAX_W-1:0] val;
  } narrow_t;

  // value is sign-extended to MAX_W by the caller; out_w must be 1..MAX_W-1.
  // Callers keep val[out_w-1:0]; with sat=0 that is the wrapped low bits.
  function automatic narrow_t narrow_sat(input logic signed [MAX_W-1:0] value,
                                         input int unsigned             out_w,
                                         input logic                    sat);
    narrow_t                 r;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    hi    = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo    = -hi - 64'sd1;
    r.ovf = 1'b0;
    r.val = value;
    if (value > hi) begin
      r.ovf = 1'b1;
      if (sat) r.val = hi;
    end else if (value < lo) begin
      r.ovf = 1'b1;
      if (sat) r.val = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/mvu_out_fifo.sv
// Generic register FIFO with occupancy count; head entry visible on data_o.
module mvu_out_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i & (cnt_q != '0);
  // A pop frees the head in the same cycle, so a full FIFO may still accept.
  assign do_push = push_i & ((cnt_q != CW'(DEPTH)) | do_pop);

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
    else if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/mvu_out_stage.sv
// MVU output stage: captures core results, narrows each lane, buffers them
// and streams them out, stalling the core through en when the FIFO is full.
module mvu_out_stage
  import mvu_pkg::*;
#(
  parameter int PE         = 1,
  parameter int ACCU_WIDTH = 24,
  parameter int OUT_WIDTH  = 16,
  parameter int SATURATE   = 1,
  parameter int DEPTH      = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en_in,
  output logic                                en,
  input  logic                                vld,
  input  logic [PE-1:0][ACCU_WIDTH-1:0]       p,
  output logic [PE*OUT_WIDTH-1:0]             m_axis_tdata,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic [$clog2(DEPTH+1)-1:0]          count,
  output logic                                ovf
);
  localparam int CW = $clog2(DEPTH+1);

  logic [PE*OUT_WIDTH-1:0] narrowed;
  logic [PE-1:0]           lane_ovf;
  logic                    capture;
  logic                    ovf_q, ovf_d;

  for (genvar g = 0; g < PE; g++) begin : g_lane
    narrow_t                 n;
    logic signed [MAX_W-1:0] ext;
    logic                    unused_hi;
    assign ext = {{(MAX_W-ACCU_WIDTH){p[g][ACCU_WIDTH-1]}}, p[g]};
    always_comb n = narrow_sat(ext, OUT_WIDTH, SATURATE != 0);
    assign narrowed[g*OUT_WIDTH +: OUT_WIDTH] = n.val[OUT_WIDTH-1:0];
    assign lane_ovf[g] = n.ovf;
    assign unused_hi   = ^n.val[MAX_W-1:OUT_WIDTH];
  end

  // en only looks at registered count, never at tready.
  assign en      = en_in & ~rst & (count < CW'(DEPTH));
  assign capture = vld & en;

  mvu_out_fifo #(.DEPTH(DEPTH), .WIDTH(PE*OUT_WIDTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (capture),
    .pop_i   (m_axis_tvalid & m_axis_tready),
    .data_i  (narrowed),
    .data_o  (m_axis_tdata),
    .count_o (count)
  );

  assign m_axis_tvalid = (count != '0);

  assign ovf_d = ovf_q | (capture & (|lane_ovf));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;

endmodule

// File: tb/tb_mvu_out_stage.sv
// Directed bench for mvu_out_stage: saturating and wrapping instances plus an
// identity-width instance, all fed by one modelled core.
module tb_mvu_out_stage;
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en_in = 1'b0;
  logic             vld = 1'b0;
  logic             tready = 1'b0;
  logic [1:0][23:0] p = '0;
  logic [0:0][23:0] p2;
  logic             en0, en1, en2;
  logic [31:0]      tdata0, tdata1;
  logic [23:0]      tdata2;
  logic             tvalid0, tvalid1, tvalid2;
  logic [2:0]       count0, count1, count2;
  logic             ovf0, ovf1, ovf2;

  int          checks = 0;
  int          errors = 0;
  longint      v0[$];
  longint      v1[$];
  int          idx = 0;
  logic [31:0] got[$];
  logic        last_en;

  assign p2[0] = p[0];

  always #5 clk = ~clk;

  mvu_out_stage #(.PE(2), .ACCU_WIDTH(24), .OUT_WIDTH(16), .SATURATE(1), .DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .en_in(en_in), .en(en0), .vld(vld), .p(p),
    .m_axis_tdata(tdata0), .m_axis_tvalid(tvalid0), .m_axis_tready(tready),
    .count(count0), .ovf(ovf0));

  mvu_out_stage #(.PE(2), .ACCU_WIDTH(24), .OUT_WIDTH(16), .SATURATE(0), .DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .en_in(en_in), .en(en1), .vld(vld), .p(p),
    .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tready(tready),
    .count(count1), .ovf(ovf1));

  mvu_out_stage #(.PE(1), .ACCU_WIDTH(24), .OUT_WIDTH(24), .SATURATE(1), .DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .en_in(en_in), .en(en2), .vld(vld), .p(p2),
    .m_axis_tdata(tdata2), .m_axis_tvalid(tvalid2), .m_axis_tready(tready),
    .count(count2), .ovf(ovf2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] nar(input longint v, input bit sat);
    logic [63:0] b;
    b = v;
    if (v > 32767)  return sat ? 16'h7FFF : b[15:0];
    if (v < -32768) return sat ? 16'h8000 : b[15:0];
    return b[15:0];
  endfunction

  function automatic logic [31:0] exp_beat(input int k);
    return {nar(v1[k], 1'b1), nar(v0[k], 1'b1)};
  endfunction

  // One clock of the core model: present result idx, advance it on vld & en.
  task automatic cycle();
    logic        hs, fire;
    logic [31:0] beat;
    if (idx < v0.size()) begin
      vld  = 1'b1;
      p[0] = 24'(v0[idx]);
      p[1] = 24'(v1[idx]);
    end else vld = 1'b0;
    #1;
    hs      = tvalid0 & tready;
    beat    = tdata0;
    fire    = vld & en0;
    last_en = en0;
    @(posedge clk); #1;
    if (hs)   got.push_back(beat);
    if (fire) idx++;
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_len"}, got.size(), v0.size());
    for (int k = 0; k < got.size() && k < v0.size(); k++) chk(tag, got[k], exp_beat(k));
    got.delete(); v0.delete(); v1.delete(); idx = 0;
  endtask

  initial begin
    int     budget;
    bit     any_ovf;
    longint r;
    en_in = 1'b1;
    #3;
    chk("rst_count", count0, 0);
    chk("rst_tvalid", tvalid0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_en", en0, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // back-to-back flow
    tready = 1'b1;
    for (int k = 0; k < 5; k++) begin v0.push_back(100 + k); v1.push_back(-100 - k); end
    cycle();
    chk("lat_tvalid", tvalid0, 1);
    chk("lat_tdata", tdata0, 32'hFF9C_0064);
    chk("lat_en", last_en, 1);
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("b2b_en", last_en, 1);
    end
    check_stream("b2b");
    chk("b2b_ovf", ovf0, 0);

    // saturation vs wrap vs identity width
    tready = 1'b0;
    v0.push_back(40000); v1.push_back(-40000);
    cycle();
    chk("sat_data", tdata0, 32'h8000_7FFF);
    chk("wrap_data", tdata1, 32'h63C0_9C40);
    chk("sat_ovf", ovf0, 1);
    chk("wrap_ovf", ovf1, 1);
    chk("id_data", tdata2, 24'd40000);
    chk("id_ovf", ovf2, 0);
    tready = 1'b1;
    v0.push_back(5); v1.push_back(6);
    cycle(); cycle(); cycle();
    chk("ovf_sticky", ovf0, 1);
    chk("wrap_sticky", ovf1, 1);
    check_stream("sat");

    // backpressure: six offered, four fit
    tready = 1'b0;
    for (int k = 0; k < 6; k++) begin v0.push_back(1000 * (k + 1)); v1.push_back(-(k + 1)); end
    for (int c = 0; c < 8; c++) cycle();
    chk("bp_count", count0, 4);
    chk("bp_en", last_en, 0);
    chk("bp_tvalid", tvalid0, 1);
    chk("bp_idx", idx, 4);
    // pop at full: en stays low that cycle, reopens the next
    tready = 1'b1;
    cycle();
    chk("full_pop_en", last_en, 0);
    chk("full_pop_count", count0, 3);
    cycle();
    chk("reopen_en", last_en, 1);
    budget = 0;
    while (got.size() < 6 && budget < 40) begin cycle(); budget++; end
    chk("bp_drained", count0, 0);
    check_stream("bp");

    // async reset mid-stream
    tready = 1'b0;
    for (int k = 0; k < 3; k++) begin v0.push_back(7 + k); v1.push_back(-7 - k); end
    cycle(); cycle(); cycle();
    chk("pre_rst_count", count0, 3);
    #1; rst = 1'b1; vld = 1'b0; #1;
    chk("arst_tvalid", tvalid0, 0);
    chk("arst_count", count0, 0);
    chk("arst_ovf", ovf0, 0);
    chk("arst_en", en0, 0);
    got.delete(); v0.delete(); v1.delete(); idx = 0;
    #1; rst = 1'b0;
    tready = 1'b1;
    v0.push_back(-32768); v1.push_back(32767);
    cycle();
    chk("post_rst_tvalid", tvalid0, 1);
    chk("post_rst_tdata", tdata0, 32'h7FFF_8000);
    cycle();
    chk("post_rst_ovf", ovf0, 0);
    check_stream("post_rst");

    // stall transparency with random en_in
    any_ovf = 1'b0;
    for (int k = 0; k < 24; k++) begin
      r = longint'($urandom_range(0, 32'h00FF_FFFF)) - 64'sd8388608;
      if (k % 2 == 0) r = r / 300;
      v0.push_back(r);
      r = longint'($urandom_range(0, 32'h00FF_FFFF)) - 64'sd8388608;
      if (k % 3 == 0) r = r / 300;
      v1.push_back(r);
      if (v0[k] > 32767 || v0[k] < -32768 || v1[k] > 32767 || v1[k] < -32768) any_ovf = 1'b1;
    end
    budget = 0;
    while (got.size() < 24 && budget < 400) begin
      en_in = 1'($urandom_range(0, 1));
      cycle();
      budget++;
    end
    en_in = 1'b1;
    cycle(); cycle();
    chk("stall_ovf", ovf0, 32'(any_ovf));
    chk("stall_count", count0, 0);
    check_stream("stall");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
